// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch timekeeping engine: prescaler divide ratio,
// per-digit BCD limits and the lap-freeze state encoding.
package stopwatch_pkg;

  localparam int CS_MAX     = 9;
  localparam int S_TENS_MAX = 5;
  localparam int M_TENS_MAX = 5;
  localparam int NUM_DIGITS = 6;

  typedef enum logic {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } lap_state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Digit order is cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens.
  function automatic int digit_max(input int idx);
    return (idx == 3) ? S_TENS_MAX : (idx == 5) ? M_TENS_MAX : CS_MAX;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit that wraps at MAX; carry is combinational so a whole
// chain of digits advances in the same clock as the tick.
module bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  localparam logic [3:0] MAX_L = 4'(MAX);

  logic [3:0] digit_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_reg <= '0;
    end else if (clr) begin
      digit_reg <= '0;
    end else if (inc) begin
      digit_reg <= (digit_reg == MAX_L) ? 4'd0 : digit_reg + 4'd1;
    end
  end

  assign digit = digit_reg;
  // Clear must suppress the carry so a clear in the wrap cycle never raises wrap.
  assign carry = inc && !clr && (digit_reg == MAX_L);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping engine: prescaler, six-digit BCD carry chain,
// lap-freeze FSM with snapshot, and registered display outputs.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       lap_active,
  output logic       wrap
);

  localparam int              DIV        = calc_div(CLK_HZ, TICK_HZ);
  localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_reg;
  logic          tick;

  // Prescaler holds while paused so resume keeps the sub-tick fraction.
  assign tick = run && (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (clear || tick) begin
      presc_reg <= '0;
    end else if (run) begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  logic [NUM_DIGITS:0]     inc_chain;
  logic [4*NUM_DIGITS-1:0] live_bus;
  logic [4*NUM_DIGITS-1:0] disp_bus;

  assign inc_chain[0] = tick;

  lap_state_e state_reg, state_next;
  logic       snap_pend_reg, snap_pend_next;
  logic       show_snap;

  // Lap takes the snapshot one cycle later from the registered count, which by
  // then already contains any increment from the lap cycle itself.
  always_comb begin
    state_next     = state_reg;
    snap_pend_next = 1'b0;
    if (clear) begin
      state_next = LIVE;
    end else if (lap) begin
      if (state_reg == LIVE) begin
        state_next     = FROZEN;
        snap_pend_next = 1'b1;
      end else begin
        state_next = LIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LIVE;
      snap_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      snap_pend_reg <= snap_pend_next;
    end
  end

  assign show_snap = (state_reg == FROZEN) && !snap_pend_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] snap_reg;
      logic [3:0] disp_reg;

      bcd_digit #(
        .MAX(digit_max(gi))
      ) u_digit (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear),
        .inc  (inc_chain[gi]),
        .digit(live_bus[gi*4 +: 4]),
        .carry(inc_chain[gi+1])
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          snap_reg <= '0;
          disp_reg <= '0;
        end else if (clear) begin
          snap_reg <= '0;
          disp_reg <= '0;
        end else begin
          if (snap_pend_reg) begin
            snap_reg <= live_bus[gi*4 +: 4];
          end
          disp_reg <= show_snap ? snap_reg : live_bus[gi*4 +: 4];
        end
      end

      assign disp_bus[gi*4 +: 4] = disp_reg;
    end
  endgenerate

  logic wrap_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= inc_chain[NUM_DIGITS];
    end
  end

  assign cs_ones    = disp_bus[3:0];
  assign cs_tens    = disp_bus[7:4];
  assign s_ones     = disp_bus[11:8];
  assign s_tens     = disp_bus[15:12];
  assign m_ones     = disp_bus[19:16];
  assign m_tens     = disp_bus[23:20];
  assign lap_active = (state_reg == FROZEN);
  assign wrap       = wrap_reg;

endmodule
